bus_protocol_checker: RTL



---
 rtl/bus_protocol_checker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_protocol_checker.sv
// rtl/bus_protocol_checker.sv - passive OCP-style bus checker: outstanding tracking, completion counters, sticky errors
module bus_protocol_checker #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int WRITERESP_ENABLE = 1,
  parameter int BYTEEN           = 0,
  parameter int DATAACCEPT_CHECK = 1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic [2:0]                           MCmd,
  input  logic [ADDR_WIDTH-1:0]                MAddr,
  input  logic [DATA_WIDTH-1:0]                MData,
  input  logic                                 MDataValid,
  input  logic [DATA_WIDTH/8-1:0]              MByteEn,
  input  logic                                 MRespAccept,
  input  logic                                 SCmdAccept,
  input  logic                                 SDataAccept,
  input  logic [1:0]                           SResp,
  input  logic [DATA_WIDTH-1:0]                SData,
  input  logic                                 Clear,
  output logic [6:0]                           Err,
  output logic                                 Err_valid,
  output logic [2:0]                           Err_first,
  output logic [$clog2(MAX_OUTSTANDING):0]     In_flight,
  output logic [CNT_WIDTH-1:0]                 Rd_count,
  output logic [CNT_WIDTH-1:0]                 Wr_count
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  logic [MAX_OUTSTANDING-1:0] fifo_rd;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic                       req_pend, rsp_pend, be_armed;
  logic [2:0]                 cap_cmd;
  logic [ADDR_WIDTH-1:0]      cap_addr;
  logic [DATA_WIDTH-1:0]      cap_data, cap_sdata;
  logic                       cap_dv;
  logic [BW-1:0]              cap_be, prev_be;
  logic [1:0]                 cap_resp;

  logic                 req_acc, rsp_acc, push_req, do_push, do_pop, fifo_empty, fifo_full;
  logic                 rd_inc, wr_inc;
  logic [6:0]           new_err;
  logic [2:0]           first_idx;
  logic [CNT_WIDTH-1:0] rd_base, wr_base;

  always_comb begin
    req_acc    = (MCmd != CMD_IDLE) && SCmdAccept;
    rsp_acc    = (SResp != 2'd0) && MRespAccept;
    fifo_empty = (In_flight == '0);
    fifo_full  = (In_flight == CW'(MAX_OUTSTANDING));
    push_req   = req_acc && ((MCmd == CMD_RD) || ((MCmd == CMD_WR) && (WRITERESP_ENABLE != 0)));
    do_pop     = rsp_acc && !fifo_empty;
    do_push    = push_req && !(fifo_full && !do_pop);
    rd_inc     = do_pop && fifo_rd[rd_ptr];
    wr_inc     = (do_pop && !fifo_rd[rd_ptr]) ||
                 ((WRITERESP_ENABLE == 0) && req_acc && (MCmd == CMD_WR));

    new_err    = '0;
    new_err[0] = req_pend && ({MCmd, MAddr, MData, MDataValid, MByteEn} !=
                              {cap_cmd, cap_addr, cap_data, cap_dv, cap_be});
    new_err[1] = rsp_pend && ({SResp, SData} != {cap_resp, cap_sdata});
    new_err[2] = rsp_acc && fifo_empty;
    new_err[3] = push_req && fifo_full && !do_pop;
    new_err[4] = (DATAACCEPT_CHECK != 0) && SCmdAccept && !SDataAccept;
    new_err[5] = (BYTEEN == 0) && be_armed && (MByteEn != prev_be);
    new_err[6] = (MCmd > CMD_RD);

    first_idx = '0;
    for (int i = 6; i >= 0; i--)
      if (new_err[i]) first_idx = 3'(i);

    // Clear takes effect before this cycle's completions, so a coincident completion reads 1.
    rd_base = Clear ? '0 : Rd_count;
    wr_base = Clear ? '0 : Wr_count;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fifo_rd   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      In_flight <= '0;
      Rd_count  <= '0;
      Wr_count  <= '0;
      Err       <= '0;
      Err_valid <= 1'b0;
      Err_first <= '0;
      req_pend  <= 1'b0;
      rsp_pend  <= 1'b0;
      be_armed  <= 1'b0;
      cap_cmd   <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_dv    <= 1'b0;
      cap_be    <= '0;
      cap_resp  <= '0;
      cap_sdata <= '0;
      prev_be   <= '0;
    end else begin
      if (do_push) begin
        fifo_rd[wr_ptr] <= (MCmd == CMD_RD);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      In_flight <= In_flight + CW'(do_push) - CW'(do_pop);

      Rd_count <= (rd_inc && (rd_base != '1)) ? rd_base + 1'b1 : rd_base;
      Wr_count <= (wr_inc && (wr_base != '1)) ? wr_base + 1'b1 : wr_base;

      Err       <= (Clear ? 7'd0 : Err) | new_err;
      Err_valid <= (Err_valid && !Clear) || (new_err != '0);
      if ((new_err != '0) && (!Err_valid || Clear))
        Err_first <= first_idx;
      else if (Clear)
        Err_first <= '0;

      // Pending trackers recapture every stalled cycle and drop on acceptance.
      req_pend <= (MCmd != CMD_IDLE) && !SCmdAccept;
      cap_cmd  <= MCmd;
      cap_addr <= MAddr;
      cap_data <= MData;
      cap_dv   <= MDataValid;
      cap_be   <= MByteEn;
      rsp_pend  <= (SResp != 2'd0) && !MRespAccept;
      cap_resp  <= SResp;
      cap_sdata <= SData;
      prev_be  <= MByteEn;
      be_armed <= 1'b1;
    end
  end
endmodule
